// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding, default latencies and the opcode-to-control decode.
package alu_seq_pkg;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 8;
  localparam int CNT_W          = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic and_l;
    logic or_l;
    logic mul;
    logic div;
  } ctrl_t;

  function automatic ctrl_t op_ctrl(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  c.add   = 1'b1;
      OP_SUB:  c.sub   = 1'b1;
      OP_AND:  c.and_l = 1'b1;
      OP_OR:   c.or_l  = 1'b1;
      OP_MUL:  c.mul   = 1'b1;
      OP_DIV:  c.div   = 1'b1;
      default: c       = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that stops at zero; zero_o flags the final cycle of an operation.
module alu_lat_counter
  import alu_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external ALU: IDLE -> EXEC -> RESP.
// The first EXEC cycle loads the registered control lines, which then stay up for the op latency.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide,
  output logic        andSignal,
  output logic        orSignal,
  output logic [31:0] Ra,
  output logic [31:0] Rb,
  input  logic [31:0] ZHI,
  input  logic [31:0] ZLO,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] ops_done
);

  state_t      state_q;
  logic [2:0]  op_q;
  ctrl_t       ctrl_q;
  logic [31:0] ra_q, rb_q, hi_q, lo_q;
  logic        err_q;
  logic [15:0] ops_done_q;

  logic             accept, bad_req, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] lat_d;

  always_comb begin
    accept   = req_valid && (state_q == ST_IDLE);
    bad_req  = (req_op > OP_DIV) || ((req_op == OP_DIV) && (req_b == 32'd0));
    cnt_load = accept && !bad_req;
    cnt_dec  = (state_q == ST_EXEC);
    lat_d    = CNT_W'(1);
    case (req_op)
      OP_MUL:  lat_d = CNT_W'(MUL_CYCLES);
      OP_DIV:  lat_d = CNT_W'(DIV_CYCLES);
      default: lat_d = CNT_W'(1);
    endcase
  end

  alu_lat_counter #(
    .W(CNT_W)
  ) u_lat (
    .clk_i      (clock),
    .rst_i      (clear),
    .load_i     (cnt_load),
    .load_val_i (lat_d),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      ctrl_q     <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      ops_done_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q <= req_op;
            // Rejected requests never reach the ALU, so operands stay untouched.
            if (bad_req) begin
              hi_q    <= '0;
              lo_q    <= '0;
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              ra_q    <= req_a;
              rb_q    <= req_b;
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_zero) begin
            ctrl_q  <= '0;
            hi_q    <= ZHI;
            lo_q    <= ZLO;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else begin
            ctrl_q  <= op_ctrl(op_q);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ops_done_q <= ops_done_q + 16'd1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign add       = ctrl_q.add;
  assign subtract  = ctrl_q.sub;
  assign andSignal = ctrl_q.and_l;
  assign orSignal  = ctrl_q.or_l;
  assign multiply  = ctrl_q.mul;
  assign divide    = ctrl_q.div;
  assign Ra        = ra_q;
  assign Rb        = rb_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the control lines.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, Ra, Rb, ZHI, ZLO, rsp_hi, rsp_lo;
  logic        add, subtract, multiply, divide, andSignal, orSignal;
  logic [15:0] ops_done;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .add(add), .subtract(subtract), .multiply(multiply), .divide(divide),
    .andSignal(andSignal), .orSignal(orSignal), .Ra(Ra), .Rb(Rb),
    .ZHI(ZHI), .ZLO(ZLO), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy),
    .ops_done(ops_done)
  );

  // External ALU model: hi holds the product's upper word or the remainder.
  always_comb begin
    prod = {32'd0, Ra} * {32'd0, Rb};
    ZHI  = 32'd0;
    ZLO  = 32'd0;
    if (add)            ZLO = Ra + Rb;
    else if (subtract)  ZLO = Ra - Rb;
    else if (andSignal) ZLO = Ra & Rb;
    else if (orSignal)  ZLO = Ra | Rb;
    else if (multiply)  {ZHI, ZLO} = prod;
    else if (divide && (Rb != 32'd0)) begin
      ZLO = Ra / Rb;
      ZHI = Ra % Rb;
    end
  end

  // Issues one request, scrambles req_* afterwards, and watches until rsp_valid (first = edges after acceptance).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int limit, output int first, output int ctl_cycles,
                        output logic [5:0] seen, output int multi, output int opnd_bad,
                        output logic [31:0] hi, output logic [31:0] lo, output logic err);
    logic [5:0] v;
    first = -1; ctl_cycles = 0; seen = '0; multi = 0; opnd_bad = 0;
    hi = 'x; lo = 'x; err = 1'bx;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = op ^ 3'd1; req_a = ~a; req_b = ~b;
    for (int i = 0; i <= limit; i++) begin
      if (i > 0) begin @(posedge clock); #1; end
      v = {add, subtract, andSignal, orSignal, multiply, divide};
      if ($countones(v) > 1) multi++;
      if (v != 6'd0) begin
        ctl_cycles++;
        seen |= v;
        if ((Ra !== a) || (Rb !== b)) opnd_bad++;
      end
      if (rsp_valid) begin
        first = i; hi = rsp_hi; lo = rsp_lo; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({add, subtract, andSignal, orSignal, multiply, divide} !== 6'd0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {add, subtract, andSignal, orSignal, multiply, divide}); end
    checks++; if ({Ra, Rb} !== 64'd0) begin errors++; $display("FAIL reset_operands got=%h exp=0", {Ra, Rb}); end
    checks++; if ({rsp_hi, rsp_lo, rsp_err} !== 65'd0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {rsp_hi, rsp_lo, rsp_err}); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
  endtask

  task automatic test_clear_abort();
    int vld_seen;
    rsp_ready = 1'b1;
    req_op = 3'd5; req_a = 32'd100; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    checks++; if ({divide, busy} !== 2'b11) begin errors++; $display("FAIL abort_exec3 got=%b exp=11", {divide, busy}); end
    clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    checks++; if ({req_ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_idle got=%b exp=10", {req_ready, busy}); end
    checks++; if ({divide, rsp_valid} !== 2'b00) begin errors++; $display("FAIL abort_outputs got=%b exp=00", {divide, rsp_valid}); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL abort_ops_done got=%0d exp=0", ops_done); end
    vld_seen = 0;
    repeat (10) begin @(posedge clock); #1 if (rsp_valid) vld_seen++; end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL abort_no_rsp got=%0d exp=0", vld_seen); end
  endtask

  task automatic test_add();
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    rsp_ready = 1'b1;
    run_op(3'd0, 32'd5, 32'd7, 10, f, cc, sn, mu, ob, h, l, e);
    checks++; if (f !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", f); end
    checks++; if (cc !== 1) begin errors++; $display("FAIL add_ctrl_cycles got=%0d exp=1", cc); end
    checks++; if (sn !== 6'b100000) begin errors++; $display("FAIL add_ctrl_line got=%b exp=100000", sn); end
    checks++; if ((mu !== 0) || (ob !== 0)) begin errors++; $display("FAIL add_exec_clean got=%0d/%0d exp=0/0", mu, ob); end
    checks++; if ({h, l, e} !== {32'd0, 32'd12, 1'b0}) begin errors++; $display("FAIL add_result got=%h/%h/%b exp=0/c/0", h, l, e); end
    @(posedge clock); #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL add_handshake got=%b exp=01", {rsp_valid, req_ready}); end
    checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL add_ops_done got=%0d exp=1", ops_done); end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  op_t [3];
    logic [31:0] a_t [3], b_t [3], r_t [3];
    logic [5:0]  c_t [3];
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    op_t[0] = 3'd1; a_t[0] = 32'd10;      b_t[0] = 32'd3;      r_t[0] = 32'd7;      c_t[0] = 6'b010000;
    op_t[1] = 3'd2; a_t[1] = 32'hF0F0;    b_t[1] = 32'hFF00;   r_t[1] = 32'hF000;   c_t[1] = 6'b001000;
    op_t[2] = 3'd3; a_t[2] = 32'hF0F0;    b_t[2] = 32'h0F00;   r_t[2] = 32'hFFF0;   c_t[2] = 6'b000100;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_op(op_t[k], a_t[k], b_t[k], 10, f, cc, sn, mu, ob, h, l, e);
      checks++; if ((f !== 2) || (cc !== 1)) begin errors++; $display("FAIL logic%0d_timing got=%0d/%0d exp=2/1", k, f, cc); end
      checks++; if (sn !== c_t[k]) begin errors++; $display("FAIL logic%0d_ctrl got=%b exp=%b", k, sn, c_t[k]); end
      checks++; if ({h, l, e} !== {32'd0, r_t[k], 1'b0}) begin errors++; $display("FAIL logic%0d_result got=%h/%h/%b exp=0/%h/0", k, h, l, e, r_t[k]); end
      @(posedge clock); #1;
    end
    checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL logic_ops_done got=%0d exp=4", ops_done); end
  endtask

  task automatic test_mul();
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    rsp_ready = 1'b1;
    run_op(3'd4, 32'h10000, 32'h10000, 20, f, cc, sn, mu, ob, h, l, e);
    checks++; if (f !== 5) begin errors++; $display("FAIL mul_latency got=%0d exp=5", f); end
    checks++; if ((cc !== 4) || (sn !== 6'b000010)) begin errors++; $display("FAIL mul_ctrl got=%0d/%b exp=4/000010", cc, sn); end
    checks++; if ((mu !== 0) || (ob !== 0)) begin errors++; $display("FAIL mul_exec_clean got=%0d/%0d exp=0/0", mu, ob); end
    checks++; if ({h, l, e} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL mul_result got=%h/%h/%b exp=1/0/0", h, l, e); end
    @(posedge clock); #1;
  endtask

  task automatic test_div();
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    rsp_ready = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 20, f, cc, sn, mu, ob, h, l, e);
    checks++; if ((f !== 9) || (cc !== 8) || (sn !== 6'b000001)) begin
      errors++; $display("FAIL div_timing got=%0d/%0d/%b exp=9/8/000001", f, cc, sn); end
    checks++; if ({h, l, e} !== {32'd2, 32'd14, 1'b0}) begin errors++; $display("FAIL div_result got=%h/%h/%b exp=2/e/0", h, l, e); end
    @(posedge clock); #1;
    run_op(3'd5, 32'd9, 32'd0, 20, f, cc, sn, mu, ob, h, l, e);
    checks++; if ((f !== 0) || (cc !== 0)) begin errors++; $display("FAIL divz_timing got=%0d/%0d exp=0/0", f, cc); end
    checks++; if ({h, l, e} !== {32'd0, 32'd0, 1'b1}) begin errors++; $display("FAIL divz_result got=%h/%h/%b exp=0/0/1", h, l, e); end
    @(posedge clock); #1;
    checks++; if (ops_done !== 16'd7) begin errors++; $display("FAIL div_ops_done got=%0d exp=7", ops_done); end
  endtask

  task automatic test_illegal_stall();
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    rsp_ready = 1'b0;
    run_op(3'd7, 32'h1234, 32'h5678, 10, f, cc, sn, mu, ob, h, l, e);
    checks++; if ((f !== 0) || (cc !== 0)) begin errors++; $display("FAIL ill_timing got=%0d/%0d exp=0/0", f, cc); end
    checks++; if ({h, l, e} !== {32'd0, 32'd0, 1'b1}) begin errors++; $display("FAIL ill_result got=%h/%h/%b exp=0/0/1", h, l, e); end
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'd1; req_b = 32'd1;
      @(posedge clock); #1;
      checks++; if ({rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_err} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b1}) begin
        errors++; $display("FAIL ill_stall%0d got=%b%b/%h/%h/%b exp=10/0/0/1", k, rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_err); end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL ill_release got=%b exp=00", {rsp_valid, busy}); end
    checks++; if (ops_done !== 16'd8) begin errors++; $display("FAIL ill_ops_done got=%0d exp=8", ops_done); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_not_queued got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    int f, cc, mu, ob; logic [5:0] sn; logic [31:0] h, l; logic e;
    force dut.ops_done_q = 16'hFFFE;
    @(posedge clock); #1;
    release dut.ops_done_q;
    @(posedge clock); #1;
    checks++; if (ops_done !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got=%h exp=fffe", ops_done); end
    rsp_ready = 1'b1;
    run_op(3'd0, 32'd1, 32'd2, 10, f, cc, sn, mu, ob, h, l, e);
    @(posedge clock); #1;
    checks++; if (ops_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%h exp=ffff", ops_done); end
    run_op(3'd7, 32'd0, 32'd0, 10, f, cc, sn, mu, ob, h, l, e);
    @(posedge clock); #1;
    checks++; if (ops_done !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", ops_done); end
  endtask

  initial begin
    test_reset();
    test_clear_abort();
    test_add();
    test_logic_ops();
    test_mul();
    test_div();
    test_illegal_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, number of EXEC cycles held for multiply (min 1).
REQ-002 Parameter DIV_CYCLES, default 8, number of EXEC cycles held for divide (min 1).
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 clear  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  operation request.
REQ-006 req_ready  out  1  sequencer accepts a request.
REQ-007 req_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV; 6 and 7 are illegal.
REQ-008 req_a, req_b  in  32 each  operands.
REQ-009 add, subtract, multiply, divide, andSignal, orSignal  out  1 each  ALU control lines; at most one of them is high at a time.
REQ-010 Ra, Rb  out  32 each  operands driven to the ALU.
REQ-011 ZHI, ZLO  in  32 each  ALU result.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  consumer takes the result.
REQ-014 rsp_hi, rsp_lo  out  32 each  captured result.
REQ-015 rsp_err  out  1  illegal opcode or divide by zero.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 ops_done  out  16  count of completed responses; wraps from 16'hFFFF to 0.

Function
REQ-018 States: IDLE, EXEC, RESP.
REQ-019 In IDLE, req_ready shall be 1; in every other state it shall be 0.
REQ-020 On req_valid & req_ready, the block shall latch req_op, req_a and req_b.
REQ-021 On acceptance of an illegal opcode, or of DIV with req_b==0, the block shall go directly to RESP with rsp_err=1 and rsp_hi=rsp_lo=0; no control line is asserted.
REQ-022 On acceptance of any other request, the block shall load the latency counter and go to EXEC.
REQ-023 Latency is 1 cycle for ADD, SUB, AND and OR; MUL_CYCLES for MUL; DIV_CYCLES for DIV.
REQ-024 In EXEC, exactly one control line shall match the latched op, held constant for the whole EXEC period.
REQ-025 In EXEC, Ra and Rb shall equal the latched operands.
REQ-026 Outside EXEC, all control lines shall be 0; Ra and Rb keep their last values.
REQ-027 In the final EXEC cycle (counter==0), ZHI and ZLO shall be captured into rsp_hi and rsp_lo, rsp_err set to 0, and the state moves to RESP.
REQ-028 Timing: for a request accepted at edge T, a single-cycle op shall assert rsp_valid after edge T+2, and MUL shall assert it after edge T+1+MUL_CYCLES.
REQ-029 In RESP, rsp_valid shall be 1 and rsp_hi, rsp_lo and rsp_err shall be stable until rsp_ready is sampled high.
REQ-030 On rsp_ready in RESP, the block shall go to IDLE and increment ops_done; error responses count.
REQ-031 There is no bypass: a new request is accepted no earlier than the cycle after the response handshake.
REQ-032 req_valid while busy shall be ignored and not queued.
REQ-033 A change on req_* during EXEC shall not affect Ra, Rb or the control lines.

Reset
REQ-034 clear has priority over all other inputs.
REQ-035 On clear the block shall enter IDLE, zero the counter, Ra, Rb, rsp_hi, rsp_lo, rsp_err, rsp_valid, all control lines and ops_done, and set req_ready=1 on the following cycle.
REQ-036 clear asserted during EXEC or RESP shall abort the operation with no response and no ops_done increment.

Structure
REQ-037 The opcode constants, the state encoding and the default latencies shall live in a shared package alu_seq_pkg.
REQ-038 One sub-module, alu_lat_counter, shall be used: a loadable down-counter with a zero flag.
REQ-039 The ALU shall be instantiated outside this block.

Verification
REQ-040 ADD, a=5, b=7, rsp_ready=1, ALU model returns 12 -> add=1 for exactly 1 cycle, rsp_valid 2 cycles after acceptance, rsp_lo=12, rsp_hi=0, ops_done=1.
REQ-041 MUL, a=32'h10000, b=32'h10000 -> multiply=1 for 4 cycles, rsp_hi=1, rsp_lo=0, rsp_valid 5 cycles after acceptance.
REQ-042 DIV, a=9, b=0 -> divide never asserted, RESP the next cycle, rsp_err=1, rsp_hi=rsp_lo=0.
REQ-043 req_op=7 -> rsp_err=1, ops_done increments; rsp_ready held 0 for 3 cycles -> rsp_valid and data stable throughout.
REQ-044 clear asserted in the 3rd EXEC cycle of a DIV -> next cycle IDLE, divide=0, rsp_valid=0, ops_done unchanged.
REQ-045 Preload ops_done=16'hFFFF via 65535 ops, then one more op -> ops_done=0.
